// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: one requester port of the SRAM arbiter.
// Ports: req_valid/ready/we/addr/wdata, rsp_valid/rdata (+ rsp_err when
// SRAM_ARB_BOUNDS_CHECK_EN is defined). master = requester, slave = arbiter.
interface sram_port_arbiter_if #(
   parameter int data_width = 64,
   parameter int addr_width = 9
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [addr_width-1:0] req_addr;
   logic [data_width-1:0] req_wdata;
   logic                  rsp_valid;
   logic [data_width-1:0] rsp_rdata;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
`endif
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between two requesters.
// Zero-fills the SRAM after reset, then grants round-robin, one transfer
// per cycle; responses come back 2 cycles after accept (read-before-write).
// Ports: clk, rst (async, active high), p0/p1 (sram_port_arbiter_if.slave),
// sram_cen_n/wen/addr/wdata (registered), sram_rdata, init_done.
// Option: SRAM_ARB_BOUNDS_CHECK_EN adds rsp_err and suppresses SRAM
// accesses for addr >= depth.
module sram_port_arbiter #(
   parameter int data_width = 64,
   parameter int addr_width = 9,
   parameter int depth      = 400
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_port_arbiter_if.slave    p0,
   sram_port_arbiter_if.slave    p1,
   output logic                  sram_cen_n,
   output logic                  sram_wen,
   output logic [addr_width-1:0] sram_addr,
   output logic [data_width-1:0] sram_wdata,
   input  logic [data_width-1:0] sram_rdata,
   output logic                  init_done
);

   localparam logic [addr_width:0] depth_c = (addr_width+1)'(depth);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [addr_width:0]   cnt;
   logic                  ptr;
   logic                  g0;
   logic                  g1;
   logic                  xfer;
   logic                  x_we;
   logic                  x_ok;
   logic [addr_width-1:0] x_addr;
   logic [data_width-1:0] x_wdata;
   logic                  s1_vld;
   logic                  s1_port;
   logic                  s2_vld;
   logic                  s2_port;
   logic                  rsp0;
   logic                  rsp1;
   logic [data_width-1:0] rd_now;
   logic [data_width-1:0] hold0;
   logic [data_width-1:0] hold1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   // cnt counts fill writes already issued; leave INIT only once the
   // last one has been presented to the SRAM.
   always_comb begin
      state_nxt = state;
      g0        = 1'b0;
      g1        = 1'b0;
      unique case (state)
         INIT: begin
            if (cnt == depth_c) state_nxt = RUN;
         end
         RUN: begin
            g0 = p0.req_valid & (~p1.req_valid | ~ptr);
            g1 = p1.req_valid & (~p0.req_valid |  ptr);
         end
         default: state_nxt = INIT;
      endcase
   end

   assign xfer    = g0 | g1;
   assign x_we    = g1 ? p1.req_we    : p0.req_we;
   assign x_addr  = g1 ? p1.req_addr  : p0.req_addr;
   assign x_wdata = g1 ? p1.req_wdata : p0.req_wdata;

`ifdef SRAM_ARB_BOUNDS_CHECK_EN
   assign x_ok = ({1'b0, x_addr} < depth_c);
`else
   assign x_ok = 1'b1;
`endif

   assign p0.req_ready = g0;
   assign p1.req_ready = g1;

   // Pointer moves only on contention, handing priority to the loser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= 1'b0;
      else if (state == RUN && p0.req_valid && p1.req_valid)
         ptr <= ~ptr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         init_done  <= 1'b0;
         sram_cen_n <= 1'b1;
         sram_wen   <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         unique case (state)
            INIT: begin
               if (cnt < depth_c) begin
                  sram_cen_n <= 1'b0;
                  sram_wen   <= 1'b1;
                  sram_addr  <= cnt[addr_width-1:0];
                  sram_wdata <= '0;
                  cnt        <= cnt + 1'b1;
               end else begin
                  sram_cen_n <= 1'b1;
                  sram_wen   <= 1'b0;
                  init_done  <= 1'b1;
               end
            end
            RUN: begin
               sram_cen_n <= ~(xfer & x_ok);
               sram_wen   <= xfer & x_ok & x_we;
               if (xfer) begin
                  sram_addr  <= x_addr;
                  sram_wdata <= x_wdata;
               end
            end
            default: begin
               sram_cen_n <= 1'b1;
            end
         endcase
      end
   end

   // Granted-port tracking: stage 1 = SRAM access, stage 2 = response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_port <= 1'b0;
         s2_vld  <= 1'b0;
         s2_port <= 1'b0;
      end else begin
         s1_vld  <= xfer;
         s1_port <= g1;
         s2_vld  <= s1_vld;
         s2_port <= s1_port;
      end
   end

   assign rsp0 = s2_vld & ~s2_port;
   assign rsp1 = s2_vld &  s2_port;

`ifdef SRAM_ARB_BOUNDS_CHECK_EN
   logic s1_err;
   logic s2_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_err <= 1'b0;
         s2_err <= 1'b0;
      end else begin
         s1_err <= xfer & ~x_ok;
         s2_err <= s1_err;
      end
   end

   assign rd_now     = s2_err ? '0 : sram_rdata;
   assign p0.rsp_err = rsp0 & s2_err;
   assign p1.rsp_err = rsp1 & s2_err;
`else
   assign rd_now = sram_rdata;
`endif

   // rdata is live on the response cycle and held afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold0 <= '0;
         hold1 <= '0;
      end else begin
         if (rsp0) hold0 <= rd_now;
         if (rsp1) hold1 <= rd_now;
      end
   end

   assign p0.rsp_valid = rsp0;
   assign p1.rsp_valid = rsp1;
   assign p0.rsp_rdata = rsp0 ? rd_now : hold0;
   assign p1.rsp_rdata = rsp1 ? rd_now : hold1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench for sram_port_arbiter.
// Models the sram_block and a reference memory; checks every response.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
   localparam int DW    = 64;
   localparam int AW    = 9;
   localparam int DEPTH = 400;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_port_arbiter_if #(.data_width(DW), .addr_width(AW)) p0_if ();
   sram_port_arbiter_if #(.data_width(DW), .addr_width(AW)) p1_if ();

   logic          sram_cen_n;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata = '0;
   logic          init_done;

   sram_port_arbiter #(
      .data_width (DW),
      .addr_width (AW),
      .depth      (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p0         (p0_if),
      .p1         (p1_if),
      .sram_cen_n (sram_cen_n),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .init_done  (init_done)
   );

   logic [DW-1:0] mem     [512];
   logic [DW-1:0] ref_mem [512];

   always @(posedge clk) begin
      if (!sram_cen_n) begin
         sram_rdata <= mem[sram_addr];
         if (sram_wen) mem[sram_addr] <= sram_wdata;
      end
   end

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
      int            c;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   logic [DW-1:0] last0 = '0;
   logic [DW-1:0] last1 = '0;

   always @(posedge clk) cyc++;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic void accept(int p, logic we, logic [AW-1:0] a,
                                  logic [DW-1:0] wd);
      exp_t e;
      e.c = cyc + 2;
      e.e = 1'b0;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
      if (int'(a) >= DEPTH) begin
         e.d = '0;
         e.e = 1'b1;
      end else begin
         e.d = ref_mem[a];
         if (we) ref_mem[a] = wd;
      end
`else
      e.d = ref_mem[a];
      if (we) ref_mem[a] = wd;
`endif
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic re0;
      logic re1;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
      re0 = p0_if.rsp_err;
      re1 = p1_if.rsp_err;
`else
      re0 = 1'b0;
      re1 = 1'b0;
`endif
      if (rst) begin
         chk("cen_in_rst", sram_cen_n, 1);
         last0 = '0;
         last1 = '0;
      end else begin
         if (p0_if.req_valid && p0_if.req_ready)
            accept(0, p0_if.req_we, p0_if.req_addr, p0_if.req_wdata);
         if (p1_if.req_valid && p1_if.req_ready)
            accept(1, p1_if.req_we, p1_if.req_addr, p1_if.req_wdata);
         if (p0_if.rsp_valid) begin
            if (q0.size() == 0) chk("p0_rsp_unexp", 1, 0);
            else begin
               e = q0.pop_front();
               chk("p0_rdata", p0_if.rsp_rdata, e.d);
               chk("p0_lat", cyc, e.c);
               chk("p0_err", re0, e.e);
               last0 = p0_if.rsp_rdata;
            end
         end else chk("p0_hold", p0_if.rsp_rdata, last0);
         if (p1_if.rsp_valid) begin
            if (q1.size() == 0) chk("p1_rsp_unexp", 1, 0);
            else begin
               e = q1.pop_front();
               chk("p1_rdata", p1_if.rsp_rdata, e.d);
               chk("p1_lat", cyc, e.c);
               chk("p1_err", re1, e.e);
               last1 = p1_if.rsp_rdata;
            end
         end else chk("p1_hold", p1_if.rsp_rdata, last1);
      end
   end

   task automatic set_req(int p, logic v, logic we, int a, logic [DW-1:0] wd);
      if (p == 0) begin
         p0_if.req_valid = v;
         p0_if.req_we    = we;
         p0_if.req_addr  = AW'(a);
         p0_if.req_wdata = wd;
      end else begin
         p1_if.req_valid = v;
         p1_if.req_we    = we;
         p1_if.req_addr  = AW'(a);
         p1_if.req_wdata = wd;
      end
   endtask

   task automatic send(int p, logic we, int a, logic [DW-1:0] wd);
      int n;
      logic r;
      n = 0;
      set_req(p, 1'b1, we, a, wd);
      forever begin
         @(negedge clk);
         r = (p == 0) ? p0_if.req_ready : p1_if.req_ready;
         if (r) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      set_req(p, 1'b0, 1'b0, 0, '0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain", q0.size() + q1.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_init(string tag, int want);
      int n;
      n = 0;
      while (!init_done && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 10) begin
            set_req(0, 1'b1, 1'b0, 3, '0);
            #1;
            chk("init_ready", p0_if.req_ready, 0);
            set_req(0, 1'b0, 1'b0, 0, '0);
         end
      end
      chk(tag, n, want);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int a0;
      int a1;
      logic w0;
      for (int i = 0; i < 512; i++) begin
         mem[i]     = {$urandom, $urandom};
         ref_mem[i] = mem[i];
      end
      set_req(0, 1'b0, 1'b0, 0, '0);
      set_req(1, 1'b0, 1'b0, 0, '0);
      repeat (3) @(negedge clk);

      chk("rst_cen_n", sram_cen_n, 1);
      chk("rst_wen", sram_wen, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_wdata", sram_wdata, 0);
      chk("rst_rdy0", p0_if.req_ready, 0);
      chk("rst_rdy1", p1_if.req_ready, 0);
      chk("rst_rv0", p0_if.rsp_valid, 0);
      chk("rst_rv1", p1_if.rsp_valid, 0);
      chk("rst_rd0", p0_if.rsp_rdata, 0);
      chk("rst_init", init_done, 0);

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      rst = 1'b0;
      wait_init("init_lat", DEPTH + 1);
      send(0, 1'b0, 0, '0);
      send(0, 1'b0, DEPTH - 1, '0);
      drain();

      send(0, 1'b1, 5, 64'hDEAD_BEEF);
      send(1, 1'b0, 5, '0);
      drain();

      a0 = 30;
      a1 = 30;
      set_req(0, 1'b1, 1'b1, a0, DW'(a0 + 'hA00));
      set_req(1, 1'b1, 1'b0, a1, '0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         w0 = p0_if.req_ready;
         chk("arb_g0", w0, (k % 2) == 0);
         chk("arb_g1", p1_if.req_ready, (k % 2) != 0);
         @(posedge clk);
         #1;
         if (w0) begin
            a0++;
            set_req(0, 1'b1, 1'b1, a0, DW'(a0 + 'hA00));
         end else begin
            a1++;
            set_req(1, 1'b1, 1'b0, a1, '0);
         end
      end
      set_req(0, 1'b0, 1'b0, 0, '0);
      set_req(1, 1'b0, 1'b0, 0, '0);
      drain();

      send(0, 1'b0, DEPTH, '0);
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
      chk("oob_cen_n", sram_cen_n, 1);
`else
      chk("oob_cen_n", sram_cen_n, 0);
`endif
      drain();

      send(0, 1'b1, 7, 64'h1);
      send(0, 1'b1, 7, 64'h2);
      send(0, 1'b0, 7, '0);
      drain();

      send(0, 1'b1, 9, 64'h55);
      drain();
      send(0, 1'b0, 9, '0);
      send(1, 1'b0, 5, '0);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      #1;
      chk("rst_mid_cen", sram_cen_n, 1);
      chk("rst_mid_rv0", p0_if.rsp_valid, 0);
      chk("rst_mid_rv1", p1_if.rsp_valid, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_init("reinit_lat", DEPTH + 1);
      send(0, 1'b0, 9, '0);
      send(1, 1'b0, 5, '0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
